// File: rtl/gpio_seq_pkg.sv
// +----------------------------------------------------------------------+
// | gpio_seq_pkg : shared types and config map for gpio_pattern_seq      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package gpio_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] PAT_BASE  = 4'd0;
    localparam logic [3:0] LEN_ADDR  = 4'd8;
    localparam logic [3:0] PRESC_LO  = 4'd9;
    localparam logic [3:0] PRESC_HI  = 4'd10;
    localparam logic [3:0] CTRL_ADDR = 4'd11;
    localparam logic [3:0] PARK_ADDR = 4'd12;

    localparam int CTRL_LOOP_BIT = 0;

    // A zero or oversized length means "use every entry".
    function automatic logic [3:0] sat_len(input logic [3:0] v, input logic [3:0] max_len);
        return ((v == 4'd0) || (v > max_len)) ? max_len : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_pattern_seq_if.sv
// +----------------------------------------------------------------------+
// | gpio_pattern_seq_if : config write port and GPIO register write port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface gpio_pattern_seq_if;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       gpio_we;
    logic [3:0] gpio_addr;
    logic [7:0] gpio_wdata;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata,
        output gpio_we, gpio_addr, gpio_wdata
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata,
        input  gpio_we, gpio_addr, gpio_wdata
    );
endinterface

`default_nettype wire

// File: rtl/gpio_seq_prescaler.sv
// +----------------------------------------------------------------------+
// | gpio_seq_prescaler : loadable down-counter with zero flag            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gpio_seq_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/gpio_pattern_seq.sv
// +----------------------------------------------------------------------+
// | gpio_pattern_seq : plays stored byte patterns into the GPIO register |
// | Optional macro GPIO_PATTERN_SEQ_PARK_EN adds a PARK write on exit.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gpio_pattern_seq
    import gpio_seq_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter int         PRESC_W   = 16,
    parameter logic [3:0] GPIO_ADDR = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gpio_pattern_seq_if.master       seq_bus,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] c_LEN_MAX = 4'(DEPTH);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_gpio_we;
    logic [7:0]           r_gpio_wdata;
    logic [7:0]           r_pat [DEPTH];
    logic [3:0]           r_len;
    logic [PRESC_W-1:0]   r_presc;
    logic                 r_loop;
`ifdef GPIO_PATTERN_SEQ_PARK_EN
    logic [7:0]           r_park;
`endif

    logic                 w_cfg_ok;
    logic                 w_pat_we;
    logic [15:0]          w_presc_ext;
    logic                 w_zero;
    logic                 w_last;
    logic                 w_step;
    logic                 w_start;
    logic                 w_load;
    logic                 w_dec;
    logic [IDX_W-1:0]     w_next_idx;
    logic [IDX_W-1:0]     w_fetch_idx;
    logic [7:0]           w_fetch_data;

    // Control registers are frozen during a run; pattern bytes stay writable.
    assign w_cfg_ok = seq_bus.cfg_we && (r_state == IDLE);
    assign w_pat_we = seq_bus.cfg_we && (seq_bus.cfg_addr < (PAT_BASE + c_LEN_MAX));

    always_comb begin
        w_presc_ext = 16'(r_presc);
        if (seq_bus.cfg_addr == PRESC_LO) begin
            w_presc_ext[7:0] = seq_bus.cfg_wdata;
        end else if (seq_bus.cfg_addr == PRESC_HI) begin
            w_presc_ext[15:8] = seq_bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pat_we) begin
            r_pat[seq_bus.cfg_addr[IDX_W-1:0]] <= seq_bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= c_LEN_MAX;
            r_presc <= '0;
            r_loop  <= 1'b0;
`ifdef GPIO_PATTERN_SEQ_PARK_EN
            r_park  <= 8'h00;
`endif
        end else if (w_cfg_ok) begin
            case (seq_bus.cfg_addr)
                LEN_ADDR:           r_len   <= sat_len(seq_bus.cfg_wdata[3:0], c_LEN_MAX);
                PRESC_LO, PRESC_HI: r_presc <= w_presc_ext[PRESC_W-1:0];
                CTRL_ADDR:          r_loop  <= seq_bus.cfg_wdata[CTRL_LOOP_BIT];
`ifdef GPIO_PATTERN_SEQ_PARK_EN
                PARK_ADDR:          r_park  <= seq_bus.cfg_wdata;
`endif
                default: ;
            endcase
        end
    end

    assign w_last       = ({{(4-IDX_W){1'b0}}, r_idx} == (r_len - 4'd1));
    assign w_step       = w_zero && (!w_last || r_loop);
    assign w_start      = (r_state == IDLE) && start && !stop;
    assign w_load       = w_start || ((r_state == RUN) && !stop && w_step);
    assign w_dec        = (r_state == RUN) && !w_zero;
    assign w_next_idx   = w_last ? '0 : r_idx + IDX_W'(1);
    assign w_fetch_idx  = (r_state == RUN) ? w_next_idx : '0;
    assign w_fetch_data = r_pat[w_fetch_idx];

    gpio_seq_prescaler #(
        .WIDTH      (PRESC_W)
    ) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (r_presc),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_gpio_we    <= 1'b0;
            r_gpio_wdata <= 8'h00;
        end else begin
            r_gpio_we <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= RUN;
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                        r_gpio_we    <= 1'b1;
                        r_gpio_wdata <= w_fetch_data;
                    end
                end
                RUN: begin
                    // Abort and normal completion share the exit path; only completion pulses done.
                    if (stop || (w_zero && !w_step)) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= !stop;
`ifdef GPIO_PATTERN_SEQ_PARK_EN
                        r_gpio_we    <= 1'b1;
                        r_gpio_wdata <= r_park;
`endif
                    end else if (w_step) begin
                        r_idx        <= w_next_idx;
                        r_gpio_we    <= 1'b1;
                        r_gpio_wdata <= w_fetch_data;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign step_idx           = r_idx;
    assign seq_bus.gpio_we    = r_gpio_we;
    assign seq_bus.gpio_wdata = r_gpio_wdata;
    assign seq_bus.gpio_addr  = GPIO_ADDR;

endmodule

`default_nettype wire

// File: tb/tb_gpio_pattern_seq.sv
// +----------------------------------------------------------------------+
// | tb_gpio_pattern_seq : scoreboard bench for gpio_pattern_seq          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gpio_pattern_seq;

    typedef struct {
        int         cyc;
        int         idx;
        bit         park;
        logic [7:0] pdata;
    } wr_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;

    gpio_pattern_seq_if bus();

    gpio_pattern_seq #(
        .DEPTH     (8),
        .PRESC_W   (16),
        .GPIO_ADDR (4'h0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seq_bus  (bus),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] m_pat [8];
    int         m_len   = 8;
    int         m_presc = 0;
    bit         m_loop  = 1'b0;
    logic [7:0] m_park  = 8'h00;
    int         m_from  = 0;
    int         m_to    = 0;
    int         m_P     = 0;
    int         m_L     = 8;
    logic [7:0] m_last  = 8'h00;
    wr_t        exp_wr[$];
    int         exp_done[$];

    bit         mon_en     = 1'b0;
    int         n_pass     = 0;
    int         n_tot      = 0;
    int         n_wr       = 0;
    int         last_wr    = -1;
    int         last_done  = -1;
    logic [7:0] last_wdata = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic bit in_run(input int c);
        return (c >= m_from) && (c < m_to);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cfg(input int c, input logic [3:0] a, input logic [7:0] d);
        if (a < 4'd8) m_pat[a[2:0]] = d;
        else if (!in_run(c)) begin
            case (a)
                4'd8:  m_len   = ((d[3:0] == 4'd0) || (d[3:0] > 4'd8)) ? 8 : int'(d[3:0]);
                4'd9:  m_presc = (m_presc & 32'hff00) | int'(d);
                4'd10: m_presc = (m_presc & 32'h00ff) | (int'(d) << 8);
                4'd11: m_loop  = d[0];
`ifdef GPIO_PATTERN_SEQ_PARK_EN
                4'd12: m_park  = d;
`endif
                default: ;
            endcase
        end
    endtask

    task automatic model_start(input int c);
        if (in_run(c)) return;
        m_from = c + 1;
        m_P    = m_presc;
        m_L    = m_len;
        if (!m_loop) begin
            for (int k = 0; k < m_L; k++) exp_wr.push_back('{c + 1 + k * (m_P + 1), k, 1'b0, 8'h00});
            m_to = c + 1 + m_L * (m_P + 1);
            exp_done.push_back(m_to);
`ifdef GPIO_PATTERN_SEQ_PARK_EN
            exp_wr.push_back('{m_to, 0, 1'b1, m_park});
`endif
        end else begin
            for (int k = 0; k < 64; k++) exp_wr.push_back('{c + 1 + k * (m_P + 1), k % m_L, 1'b0, 8'h00});
            m_to = 1 << 30;
        end
    endtask

    task automatic model_stop(input int c);
        wr_t keep_wr[$];
        int  keep_done[$];
        if (!in_run(c)) return;
        m_to = c + 1;
        foreach (exp_wr[i])   if (exp_wr[i].cyc <= c) keep_wr.push_back(exp_wr[i]);
        foreach (exp_done[i]) if (exp_done[i] <= c)   keep_done.push_back(exp_done[i]);
        exp_wr   = keep_wr;
        exp_done = keep_done;
`ifdef GPIO_PATTERN_SEQ_PARK_EN
        exp_wr.push_back('{c + 1, 0, 1'b1, m_park});
`endif
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        model_cfg(cyc, a, d);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start(cyc);
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        model_stop(cyc);
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((cyc < m_to + 1 || exp_wr.size() != 0 || exp_done.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("pending_after_wait", exp_wr.size() + exp_done.size(), 0);
        chk("busy_after_wait", int'(busy), 0);
    endtask

    task automatic load_cfg(input int len, input int presc, input bit loop_en);
        cfg_wr(4'd8,  8'(len));
        cfg_wr(4'd9,  8'(presc));
        cfg_wr(4'd10, 8'(presc >> 8));
        cfg_wr(4'd11, {7'd0, loop_en});
    endtask

    // Monitor: compares every cycle against the model's schedule
    always @(negedge clk) begin : mon
        wr_t        e;
        logic [7:0] d;
        if (mon_en) begin
            chk("busy", int'(busy), int'(in_run(cyc)));
            chk("step_idx", int'(step_idx), in_run(cyc) ? ((cyc - m_from) / (m_P + 1)) % m_L : 0);
            while (exp_wr.size() != 0 && exp_wr[0].cyc < cyc) begin
                chk("missing_write", -1, exp_wr[0].cyc);
                void'(exp_wr.pop_front());
            end
            while (exp_done.size() != 0 && exp_done[0] < cyc) begin
                chk("missing_done", -1, exp_done[0]);
                void'(exp_done.pop_front());
            end
            if (bus.gpio_we) begin
                n_wr++;
                last_wr    = cyc;
                last_wdata = bus.gpio_wdata;
                if (exp_wr.size() == 0) chk("unexpected_write", cyc, -1);
                else begin
                    e = exp_wr.pop_front();
                    d = e.park ? e.pdata : m_pat[e.idx];
                    chk("write_cycle", cyc, e.cyc);
                    chk("write_data", int'(bus.gpio_wdata), int'(d));
                    chk("gpio_addr", int'(bus.gpio_addr), 0);
                    m_last = d;
                end
            end else begin
                chk("wdata_hold", int'(bus.gpio_wdata), int'(m_last));
            end
            if (done) begin
                last_done = cyc;
                if (exp_done.size() == 0) chk("unexpected_done", cyc, -1);
                else chk("done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    initial begin : stim
        int s;
        int n0;
        int d0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 4'd0;
        bus.cfg_wdata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_step_idx", int'(step_idx), 0);
        chk("rst_gpio_we", int'(bus.gpio_we), 0);
        chk("rst_gpio_wdata", int'(bus.gpio_wdata), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Three entries, hold 3 cycles each, single pass
        cfg_wr(4'd0, 8'h11); cfg_wr(4'd1, 8'h22); cfg_wr(4'd2, 8'h33);
        load_cfg(3, 2, 1'b0);
        n0 = n_wr; s = cyc;
        do_start();
        wait_idle(100);
        chk("t1_done_rel", last_done - s, 10);
        chk("t1_write_count", n_wr - n0, 3);

        // Looping, aborted at relative cycle 12
        cfg_wr(4'd11, 8'h01);
        d0 = last_done; s = cyc;
        do_start();
        while (cyc < s + 12) tick();
        do_stop();
        wait_idle(100);
        chk("t2_last_write_rel", last_wr - s, 10);
        chk("t2_no_done", last_done, d0);

        // LEN=0 saturates to 8, back-to-back writes
        for (int a = 0; a < 8; a++) cfg_wr(4'(a), 8'($urandom_range(0, 255)));
        load_cfg(0, 0, 1'b0);
        n0 = n_wr; s = cyc;
        do_start();
        wait_idle(100);
        chk("t3_done_rel", last_done - s, 9);
        chk("t3_write_count", n_wr - n0, 8);

        // start and stop together in IDLE
        n0 = n_wr;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (4) tick();
        chk("t4_no_write", n_wr, n0);

        // start while busy does not disturb timing
        load_cfg(3, 2, 1'b0);
        s = cyc;
        do_start();
        tick();
        do_start();
        wait_idle(100);
        chk("t5_done_rel", last_done - s, 10);

        // Runtime writes: PRESC ignored, pattern entry 2 picked up
        s = cyc;
        do_start();
        tick();
        cfg_wr(4'd9, 8'd5);
        cfg_wr(4'd2, 8'hAA);
        wait_idle(100);
        chk("t6_done_rel", last_done - s, 10);
        chk("t6_step2_data", int'(last_wdata), 8'hAA);

        // Randomized runs
        for (int it = 0; it < 25; it++) begin
            for (int a = 0; a < 8; a++) cfg_wr(4'(a), 8'($urandom_range(0, 255)));
            load_cfg($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            cfg_wr(4'd12, 8'($urandom_range(0, 255)));
            do_start();
            if ($urandom_range(0, 3) == 0) begin
                tick();
                do_start();
            end
            if ($urandom_range(0, 2) == 0) cfg_wr(4'd9, 8'($urandom_range(4, 9)));
            if (m_loop || $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 30)) tick();
                do_stop();
            end
            wait_idle(600);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Asynchronous reset in the middle of a hold
        load_cfg(4, 20, 1'b0);
        do_start();
        repeat (5) tick();
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_step_idx", int'(step_idx), 0);
        chk("arst_gpio_we", int'(bus.gpio_we), 0);
        chk("arst_gpio_wdata", int'(bus.gpio_wdata), 0);
        exp_wr.delete();
        exp_done.delete();
        m_len = 8; m_presc = 0; m_loop = 1'b0; m_park = 8'h00;
        m_from = 0; m_to = 0; m_last = 8'h00;
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Defaults after reset: all 8 entries, one cycle each
        for (int a = 0; a < 8; a++) cfg_wr(4'(a), 8'($urandom_range(0, 255)));
        s = cyc;
        do_start();
        wait_idle(100);
        chk("post_rst_done_rel", last_done - s, 9);

        repeat (3) tick();
        mon_en = 1'b0;
        chk("final_queue_empty", exp_wr.size() + exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_pattern_seq.md
Name: gpio_pattern_seq

Overview:
- Autonomous pattern sequencer that drives the write port of the 8-bit GPIO output register (addr/wdata/we).
- Software loads up to DEPTH byte patterns, a step length, a prescaler and a loop bit through a small config port.
- On start, the block writes each pattern to the GPIO register in order, holding each for PRESC+1 cycles.
- Sits between the config bus and the GPIO register; it is the register's only writer while busy.

Parameters:
- DEPTH, 8, number of pattern entries (power of 2, 2..8).
- PRESC_W, 16, prescaler width in bits.
- GPIO_ADDR, 4'h0, value driven on gpio_addr for every write.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  config address
- cfg_wdata  in  8  config write data
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- busy  out  1  high while the sequence runs
- done  out  1  one-cycle pulse on normal completion
- step_idx  out  $clog2(DEPTH)  index of the entry currently presented
- gpio_we  out  1  write strobe to the GPIO register
- gpio_addr  out  4  constant GPIO_ADDR
- gpio_wdata  out  8  pattern byte

Behaviour:
- Config map:
  - 0..DEPTH-1: pattern RAM.
  - 8: LEN[3:0]. Valid range 1..DEPTH; 0 or >DEPTH saturates to DEPTH.
  - 9: PRESC[7:0].
  - 10: PRESC[15:8] (ignored bits above PRESC_W).
  - 11: CTRL, bit0 = LOOP.
  - Other addresses: write ignored.
- Reset values: busy=0, done=0, step_idx=0, gpio_we=0, gpio_wdata=0, LEN=DEPTH, PRESC=0, LOOP=0. Pattern RAM is not reset (undefined contents).
- All outputs are registered.
- FSM states:
  - IDLE: start=1 and stop=0 -> RUN. Load idx=0 and cnt=PRESC; the next cycle drives gpio_we=1, gpio_wdata=pat[0], busy=1.
  - RUN:
    - cnt>0: decrement cnt.
    - cnt==0 and idx<LEN-1: idx++, cnt=PRESC, write pat[idx+1].
    - cnt==0 and idx==LEN-1 and LOOP=1: idx=0, cnt=PRESC, write pat[0].
    - cnt==0 and idx==LEN-1 and LOOP=0: go to IDLE with done=1 for one cycle and busy=0 in that same cycle.
- Timing: with start sampled in cycle 0, entry k is written in cycle 1+k*(PRESC+1). done is asserted in cycle 1+LEN*(PRESC+1).
- gpio_we is exactly a one-cycle pulse per step. gpio_wdata holds the last value between strobes.
- stop has priority over everything: in RUN, the next cycle is IDLE with busy=0, no done and no further write. In IDLE, stop together with start means the block stays IDLE.
- start while busy is ignored.
- Config writes while busy:
  - Pattern RAM writes are accepted and take effect when that entry is next fetched.
  - LEN, PRESC and CTRL writes are ignored.
- Reset mid-sequence returns to IDLE with reset values immediately. There is no trailing gpio_we.
- step_idx follows idx and returns to 0 in IDLE.

Optional Feature:
- Macro: GPIO_PATTERN_SEQ_PARK_EN.
- When defined, config address 12 holds PARK (8 bits, reset 0). On normal completion or stop, the block issues one extra gpio_we with gpio_wdata=PARK in the cycle it enters IDLE, coincident with done on completion.
- When undefined, address 12 is ignored and no write is issued on exit, so the GPIO keeps the last pattern.

Decomposition:
- Shared package gpio_seq_pkg holds:
  - the state enum (IDLE, RUN);
  - the config address constants (PAT_BASE, LEN_ADDR, PRESC_LO, PRESC_HI, CTRL_ADDR, PARK_ADDR);
  - the CTRL bit index.
- One natural sub-module, gpio_seq_prescaler: a loadable down-counter with a zero flag, reused for step timing.
- Pattern RAM stays inline as a register array.

Test Plan:
- Load pat={11,22,33}, LEN=3, PRESC=2, LOOP=0, then pulse start at cycle 0. Required: gpio_we at cycles 1, 4 and 7 with data 11, 22, 33; done at cycle 10; busy high in cycles 1..9.
- Same setup with LOOP=1. Required: writes continue 11,22,33,11,… every 3 cycles with no done. Pulse stop at cycle 12: busy drops at cycle 13 and no write occurs after cycle 10.
- LEN=0, PRESC=0, DEPTH=8. Required: 8 consecutive single-cycle writes pat[0..7] in cycles 1..8, then done in cycle 9.
- Assert start and stop in the same cycle in IDLE -> busy stays 0 and no gpio_we. Assert start while busy -> the sequence timing is unchanged.
- While running, write PRESC=5 and pat[2]=AA before step 2. Required: step spacing is unchanged and step 2 outputs AA.
- Drop rst_n mid-hold -> all outputs return to 0 asynchronously. With GPIO_PATTERN_SEQ_PARK_EN and PARK=5A, normal completion emits a 5A write in the done cycle.
